mips16_trace_tx: RTL and testbench

Trace transmitter for the 16-bit single-cycle MIPS core. It watches the core's `pc_out` and the exported `reg2`–`reg5` debug outputs, snapshots them whenever the PC changes, and serialises each snapshot as a framed byte stream on a UART 8N1 line. It is the on-chip counterpart of the simulation-only register monitor, so register traces can be read from hardware with a serial terminal.

---
 rtl/mips16_trace_tx.sv | 214 +++++++++++++++++++++
 tb/tb_mips16_trace_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips16_trace_tx.sv
// mips16_trace_tx
// Snapshots {pc, reg2..reg5} of the 16-bit MIPS core whenever the PC changes
// and ships each snapshot as a framed UART 8N1 byte stream:
//   A5, pc hi, pc lo, reg2 hi/lo, reg3 hi/lo, reg4 hi/lo, reg5 hi/lo
// Optional feature macro: MIPS16_TRACE_CHECKSUM_EN appends a 12th byte, the
// XOR of bytes 1..10 (sync byte excluded).
// One pending snapshot is held while a frame is in flight. Further captures
// are dropped and counted in a saturating drop counter.
module mips16_trace_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_en,
    input  logic [15:0] pc_out,
    input  logic [15:0] reg2,
    input  logic [15:0] reg3,
    input  logic [15:0] reg4,
    input  logic [15:0] reg5,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

`ifdef MIPS16_TRACE_CHECKSUM_EN
    localparam int NBYTES = 12;
`else
    localparam int NBYTES = 11;
`endif
    localparam int FRAME_W = NBYTES * 8;
    localparam int CNT_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BYTE = 4'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

`ifdef MIPS16_TRACE_CHECKSUM_EN
    // XOR of the ten payload bytes of a snapshot
    function automatic logic [7:0] xor_fold(input logic [79:0] d);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 10; i++) begin
            r = r ^ d[i*8 +: 8];
        end
        return r;
    endfunction
`endif

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   clk_cnt_r, clk_cnt_nxt_s;
    logic [2:0]         bit_cnt_r, bit_cnt_nxt_s;
    logic [3:0]         byte_cnt_r, byte_cnt_nxt_s;
    logic [FRAME_W-1:0] frame_r, frame_nxt_s, frame_load_s;
    logic [7:0]         sh_r, sh_nxt_s;
    logic               tx_r, tx_nxt_s;
    logic               busy_r;
    logic [79:0]        snap_r;
    logic               snap_valid_r, snap_valid_nxt_s;
    logic [15:0]        pc_prev_r;
    logic [7:0]         drop_cnt_r;
    logic               capture_s, load_s, snap_take_s, drop_inc_s;
    logic               bit_end_s;
    logic [7:0]         cur_byte_s;

    assign capture_s  = trace_en && (pc_out != pc_prev_r);
    assign load_s     = (state_r == IDLE) && snap_valid_r;
    assign bit_end_s  = (clk_cnt_r == CNT_MAX);
    assign cur_byte_s = frame_r[FRAME_W-1 -: 8];

`ifdef MIPS16_TRACE_CHECKSUM_EN
    assign frame_load_s = {8'hA5, snap_r, xor_fold(snap_r)};
`else
    assign frame_load_s = {8'hA5, snap_r};
`endif

    // Snapshot arbitration: a capture into a register being freed this cycle wins
    always_comb begin
        snap_take_s      = 1'b0;
        drop_inc_s       = 1'b0;
        snap_valid_nxt_s = snap_valid_r;
        if (capture_s && (!snap_valid_r || load_s)) begin
            snap_take_s      = 1'b1;
            snap_valid_nxt_s = 1'b1;
        end else if (capture_s) begin
            drop_inc_s = 1'b1;
        end else if (load_s) begin
            snap_valid_nxt_s = 1'b0;
        end else begin
            snap_valid_nxt_s = snap_valid_r;
        end
    end

    // Snapshot register, PC history and saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_r       <= 80'h0;
            snap_valid_r <= 1'b0;
            pc_prev_r    <= 16'hFFFF;
            drop_cnt_r   <= 8'h00;
        end else begin
            snap_valid_r <= snap_valid_nxt_s;
            pc_prev_r    <= pc_out;
            if (snap_take_s) begin
                snap_r <= {pc_out, reg2, reg3, reg4, reg5};
            end
            if (drop_inc_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    // Serialiser next-state and next tx level (tx is registered from tx_nxt_s)
    always_comb begin
        state_nxt_s    = state_r;
        clk_cnt_nxt_s  = clk_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        byte_cnt_nxt_s = byte_cnt_r;
        frame_nxt_s    = frame_r;
        sh_nxt_s       = sh_r;
        tx_nxt_s       = tx_r;
        case (state_r)
            IDLE: begin
                if (snap_valid_r) begin
                    frame_nxt_s    = frame_load_s;
                    byte_cnt_nxt_s = 4'd0;
                    clk_cnt_nxt_s  = '0;
                    state_nxt_s    = START;
                    tx_nxt_s       = 1'b0;
                end else begin
                    tx_nxt_s = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    clk_cnt_nxt_s = '0;
                    bit_cnt_nxt_s = 3'd0;
                    tx_nxt_s      = cur_byte_s[0];
                    sh_nxt_s      = {1'b0, cur_byte_s[7:1]};
                    state_nxt_s   = DATA;
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 1'b1;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    clk_cnt_nxt_s = '0;
                    if (bit_cnt_r == 3'd7) begin
                        tx_nxt_s    = 1'b1;
                        state_nxt_s = STOP;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        tx_nxt_s      = sh_r[0];
                        sh_nxt_s      = {1'b0, sh_r[7:1]};
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 1'b1;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    clk_cnt_nxt_s = '0;
                    if (byte_cnt_r == LAST_BYTE) begin
                        tx_nxt_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        byte_cnt_nxt_s = byte_cnt_r + 4'd1;
                        frame_nxt_s    = {frame_r[FRAME_W-9:0], 8'h00};
                        tx_nxt_s       = 1'b0;
                        state_nxt_s    = START;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

    // Serialiser state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            clk_cnt_r  <= '0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 4'd0;
            frame_r    <= '0;
            sh_r       <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            clk_cnt_r  <= clk_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            frame_r    <= frame_nxt_s;
            sh_r       <= sh_nxt_s;
            tx_r       <= tx_nxt_s;
            busy_r     <= (state_nxt_s != IDLE) || snap_valid_nxt_s;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_mips16_trace_tx.sv
// Self-checking bench for mips16_trace_tx (CLKS_PER_BIT = 4).
// Expected frame bytes are pushed into a queue when a traced PC change is
// driven; a UART receiver decodes tx and pops/compares each byte.
module tb_mips16_trace_tx;

`ifdef MIPS16_TRACE_CHECKSUM_EN
    localparam int NB = 12;
`else
    localparam int NB = 11;
`endif
    localparam int CPB       = 4;
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b0;
    logic [15:0] pc_out = 16'h0000;
    logic [15:0] reg2 = 16'h0000, reg3 = 16'h0000, reg4 = 16'h0000, reg5 = 16'h0000;
    logic        tx, busy;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] exp_q[$];

    mips16_trace_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en), .pc_out(pc_out),
        .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5),
        .tx(tx), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive pc and register taps; queue the expected frame if it will be traced
    task automatic drive_snap(input logic [15:0] p, input bit traced);
        logic [15:0] r2, r3, r4, r5;
        logic [7:0]  chk;
        r2 = p ^ 16'h1111; r3 = p ^ 16'h2222; r4 = p ^ 16'h4444; r5 = p ^ 16'h8888;
        pc_out = p; reg2 = r2; reg3 = r3; reg4 = r4; reg5 = r5;
        if (traced) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(p[15:8]);  exp_q.push_back(p[7:0]);
            exp_q.push_back(r2[15:8]); exp_q.push_back(r2[7:0]);
            exp_q.push_back(r3[15:8]); exp_q.push_back(r3[7:0]);
            exp_q.push_back(r4[15:8]); exp_q.push_back(r4[7:0]);
            exp_q.push_back(r5[15:8]); exp_q.push_back(r5[7:0]);
            chk = p[15:8] ^ p[7:0] ^ r2[15:8] ^ r2[7:0] ^ r3[15:8] ^ r3[7:0]
                ^ r4[15:8] ^ r4[7:0] ^ r5[15:8] ^ r5[7:0];
            if (NB == 12) exp_q.push_back(chk);
        end
    endtask

    // Receive one UART byte; called at a negedge, returns at mid stop bit
    task automatic rx_byte(output logic [7:0] b, output bit ok, output int st);
        int n;
        n = 0; ok = 1'b0; b = 8'h00; st = cyc;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        st = cyc;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b[i] = tx;
            repeat (4) @(negedge clk);
        end
        ok = (tx === 1'b1);
    endtask

    // Receive a whole frame, compare against the scoreboard
    task automatic rx_frame(output int start_cyc);
        logic [7:0] b, e;
        bit ok;
        int st;
        start_cyc = 0;
        for (int i = 0; i < NB; i++) begin
            rx_byte(b, ok, st);
            if (i == 0) start_cyc = st;
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rx_byte%0d: no valid start/stop (timeout or framing), required a byte", i);
                break;
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_byte%0d: got %02h, required no byte", i, b);
            end else begin
                e = exp_q.pop_front();
                if (b !== e) begin
                    n_fail++;
                    $display("FAIL rx_byte%0d: got %02h, required %02h", i, b, e);
                end
            end
        end
    endtask

    // Wait for busy to fall and check frame length from start bit
    task automatic wait_idle(input int st, input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (busy !== 1'b0 || (cyc - st) != FRAME_CYC) begin
            n_fail++;
            $display("FAIL %s busy_len: busy=%b after %0d cycles, required 0 after %0d", nm, busy, cyc - st, FRAME_CYC);
        end
    endtask

    task automatic check_quiet(input int ncyc, input string nm);
        bit bad;
        bad = 1'b0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s quiet: tx/busy activity seen, required tx=1 busy=0", nm);
        end
    endtask

    task automatic check_sb_empty(input string nm);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: %0d bytes left, required 0", nm, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; trace_en = 1'b1;
        pc_out = 16'h0000; reg2 = 16'h0001; reg3 = 16'h0002; reg4 = 16'h0003; reg5 = 16'h0004;
        repeat (3) @(negedge clk);
        n_checks += 3;
        if (tx !== 1'b1)       begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_drop: got %0d, required 0", drop_cnt); end
    endtask

    task automatic test_basic_frame();
        int st;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        exp_q.push_back(8'h00); exp_q.push_back(8'h03);
        exp_q.push_back(8'h00); exp_q.push_back(8'h04);
        if (NB == 12) exp_q.push_back(8'h04);
        reset = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (tx !== 1'b1)   begin n_fail++; $display("FAIL basic_tx_edge1: got %b, required 1", tx); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_edge1: got %b, required 1", busy); end
        @(negedge clk);
        if (tx !== 1'b0)   begin n_fail++; $display("FAIL basic_tx_edge2: got %b, required 0", tx); end
        rx_frame(st);
        wait_idle(st, "basic");
        check_sb_empty("basic");
    endtask

    task automatic test_overflow();
        int st1, st2;
        fork
            begin
                @(negedge clk);
                drive_snap(16'h0010, 1'b1);
                repeat (10) @(negedge clk);
                drive_snap(16'h0011, 1'b1);
                @(negedge clk);
                drive_snap(16'h0012, 1'b0);
                @(negedge clk);
                n_checks++;
                if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_drop1: got %0d, required 1", drop_cnt); end
                drive_snap(16'h0013, 1'b0);
                @(negedge clk);
                n_checks++;
                if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop2: got %0d, required 2", drop_cnt); end
            end
            begin
                rx_frame(st1);
                rx_frame(st2);
            end
        join
        n_checks++;
        if (st2 - st1 != FRAME_CYC + 1) begin
            n_fail++;
            $display("FAIL ovf_period: got %0d cycles, required %0d", st2 - st1, FRAME_CYC + 1);
        end
        wait_idle(st2, "ovf");
        check_quiet(60, "ovf_after");
        n_checks++;
        if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_final: got %0d, required 2", drop_cnt); end
        check_sb_empty("ovf");
    endtask

    task automatic test_saturation();
        int st1, st2;
        fork
            begin
                for (int i = 0; i < 310; i++) begin
                    drive_snap(16'h0200 + 16'(i), (i < 2));
                    @(negedge clk);
                end
            end
            begin
                rx_frame(st1);
                rx_frame(st2);
            end
        join
        wait_idle(st2, "sat");
        n_checks++;
        if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop: got %0d, required 255", drop_cnt); end
        check_sb_empty("sat");
    endtask

    task automatic test_capture_disabled();
        trace_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_snap(16'h0500 + 16'(i), 1'b0);
            @(negedge clk);
        end
        check_quiet(60, "disabled");
        trace_en = 1'b1;
        check_quiet(20, "reenable_same_pc");
    endtask

    task automatic test_reset_mid_frame();
        int n, st;
        drive_snap(16'h0600, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL rmf_start: got tx=%b, required 0", tx); end
        repeat (3) @(negedge clk);
        drive_snap(16'h0601, 1'b0);
        repeat (6) @(negedge clk);
        n_checks += 4;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL rmf_data_bit1: got %b, required 0", tx); end
        #2 reset = 1'b0;
        #1;
        if (tx !== 1'b1)       begin n_fail++; $display("FAIL rmf_tx: got %b, required 1", tx); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL rmf_busy: got %b, required 0", busy); end
        if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL rmf_drop: got %0d, required 0", drop_cnt); end
        @(negedge clk);
        trace_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        trace_en = 1'b1;
        check_quiet(20, "rmf_after_release");
        drive_snap(16'h0700, 1'b1);
        rx_frame(st);
        wait_idle(st, "rmf_new");
        check_sb_empty("rmf");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow();
        test_saturation();
        test_capture_disabled();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
